// File: rtl/sd_io_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : sd_io_pkg                                             |
// | Purpose  : Shared FSM encodings and defaults for board I/O blocks |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package sd_io_pkg;

    localparam int         STATE_W    = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM_PR  = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_ARM_REL = 2'd3;

    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int c_LONG_CYCLES_DEFAULT     = 64;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : sync_2ff                                              |
// | Purpose  : Generic two-flop synchroniser, async active-low reset  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : button_debounce                                       |
// | Purpose  : Synchronise/debounce a push button; level, press,      |
// |            release, long-press (BTN_LONG_PRESS_EN) and LED toggle |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module button_debounce
    import sd_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = c_LONG_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_led
);

    localparam int                 c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
        $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic               w_sync;
    logic               w_raw;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_level_nxt;
    logic               w_press_nxt;
    logic               w_release_nxt;
    logic               w_led_nxt;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic               r_led;

    // Flops idle at the pin's released level so reset release never looks like a press.
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .i_clk   (i_clock),
        .i_rst_n (i_reset_n),
        .i_d     (i_button),
        .o_q     (w_sync)
    );

    assign w_raw = w_sync ^ ACTIVE_LOW;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_raw) begin
                    w_state_nxt = ST_ARM_PR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM_PR: begin
                if (!w_raw) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_raw) begin
                    w_state_nxt = ST_ARM_REL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM_REL: begin
                if (w_raw) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the transition so they land with the state change.
    always_comb begin
        w_press_nxt   = (r_state == ST_ARM_PR)  && (w_state_nxt == ST_HELD);
        w_release_nxt = (r_state == ST_ARM_REL) && (w_state_nxt == ST_IDLE);
        w_level_nxt   = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_ARM_REL);
        w_led_nxt     = r_led ^ w_press_nxt;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_led     <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_led     <= w_led_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_led     = r_led;

`ifdef BTN_LONG_PRESS_EN
    localparam int                  c_LCNT_W    = cnt_width(LONG_CYCLES);
    localparam logic [c_LCNT_W-1:0] c_LCNT_LAST = c_LCNT_W'(LONG_CYCLES - 1);

    logic [c_LCNT_W-1:0] r_lcnt;
    logic                r_long_done;
    logic                r_long;

    // lcnt is frozen in ARM_REL so a release bounce does not restart the long timer.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else if (r_state == ST_HELD) begin
            if (r_lcnt != c_LCNT_LAST) begin
                r_lcnt <= r_lcnt + 1'b1;
            end
            r_long <= (r_lcnt == c_LCNT_LAST) && !r_long_done;
            if (r_lcnt == c_LCNT_LAST) begin
                r_long_done <= 1'b1;
            end
        end else if (r_state == ST_ARM_REL) begin
            r_long <= 1'b0;
        end else begin
            r_lcnt      <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : tb_button_debounce                                    |
// | Purpose  : Scoreboard bench for button_debounce (D=4, L=10)       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_button_debounce;

    localparam int c_D   = 4;
    localparam int c_L   = 10;
    // Input driven after edge E is first sampled at E+1; the level moves at E+1+D+2.
    localparam int c_LAT = c_D + 3;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int kind;
        int edge_no;
    } ev_t;

    logic clk;
    logic rst_n;
    logic button;
    logic w_level;
    logic w_press;
    logic w_release;
    logic w_long;
    logic w_led;

    ev_t sb_q[$];
    int  cyc;
    int  n_checks;
    int  n_fail;
    int  n_press_exp;
    int  n_press_seen;
    int  n_rel_exp;
    int  n_rel_seen;
    int  n_long_exp;
    int  n_long_seen;
    int  led_exp;
    int  p_edge;

    button_debounce #(
        .DEBOUNCE_CYCLES (c_D),
        .LONG_CYCLES     (c_L),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_button  (button),
        .o_level   (w_level),
        .o_press   (w_press),
        .o_release (w_release),
        .o_long    (w_long),
        .o_led     (w_led)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int edge_no);
        ev_t e;
        e.kind    = kind;
        e.edge_no = edge_no;
        sb_q.push_back(e);
        if (kind == K_PRESS)   n_press_exp++;
        if (kind == K_RELEASE) n_rel_exp++;
        if (kind == K_LONG)    n_long_exp++;
    endtask

    task automatic note_pulse(input int kind);
        ev_t e;
        if (kind == K_PRESS)   n_press_seen++;
        if (kind == K_RELEASE) n_rel_seen++;
        if (kind == K_LONG)    n_long_seen++;
        if (sb_q.size() == 0) begin
            check_val("unexpected_pulse_kind", kind, -1);
        end else begin
            e = sb_q.pop_front();
            check_val("pulse_kind", kind, e.kind);
            check_val("pulse_edge", cyc, e.edge_no);
            if (kind == K_PRESS)   check_val("level_at_press", int'(w_level), 1);
            if (kind == K_RELEASE) check_val("level_at_release", int'(w_level), 0);
        end
    endtask

    // Outputs are sampled on the falling edge, mid-way between active edges.
    always @(negedge clk) begin
        if (w_press || w_release || w_long) begin
            check_val("press_release_exclusive", int'(w_press & w_release), 0);
            if (w_press)   note_pulse(K_PRESS);
            if (w_release) note_pulse(K_RELEASE);
            if (w_long)    note_pulse(K_LONG);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #0.2;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check_val({tag, "_drain"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_press();
        button  = 1'b0;
        p_edge  = cyc + c_LAT;
        push_ev(K_PRESS, p_edge);
        led_exp = led_exp ^ 1;
    endtask

    task automatic do_release();
        button = 1'b1;
        push_ev(K_RELEASE, cyc + c_LAT);
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        n_press_exp = 0; n_press_seen = 0;
        n_rel_exp = 0; n_rel_seen = 0;
        n_long_exp = 0; n_long_seen = 0;
        led_exp = 0; p_edge = 0;
        rst_n  = 1'b0;
        button = 1'b0;

        // Reset held while pressed: everything stays quiet.
        step(3);
        check_val("rst_level", int'(w_level), 0);
        check_val("rst_press", int'(w_press), 0);
        check_val("rst_release", int'(w_release), 0);
        check_val("rst_long", int'(w_long), 0);
        check_val("rst_led", int'(w_led), 0);

        // Release reset with the button still pressed.
        rst_n = 1'b1;
        push_ev(K_PRESS, cyc + c_LAT);
        led_exp = 1;
        drain("t1_press", 20);
        check_val("t1_level", int'(w_level), 1);
        check_val("t1_led", int'(w_led), led_exp);
        do_release();
        drain("t1_release", 20);
        check_val("t1_level_off", int'(w_level), 0);

        // Clean press held 20 cycles.
        do_press();
`ifdef BTN_LONG_PRESS_EN
        push_ev(K_LONG, p_edge + c_L);
`endif
        step(20);
        check_val("t2_level", int'(w_level), 1);
        check_val("t2_led", int'(w_led), led_exp);
        do_release();
        drain("t2_release", 20);
        check_val("t2_level_off", int'(w_level), 0);
        check_val("t2_led_after_release", int'(w_led), led_exp);

        // Short low glitch: rejected.
        button = 1'b0;
        step(3);
        button = 1'b1;
        step(10);
        check_val("t3_glitch_level", int'(w_level), 0);
        check_val("t3_glitch_led", int'(w_led), led_exp);

        // Press, then a short release glitch while held; long timer only pauses.
        do_press();
        drain("t3_press", 20);
        button = 1'b1;
        step(3);
        button = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        push_ev(K_LONG, p_edge + c_L + 3);
`endif
        step(40);
        check_val("t4_held_level", int'(w_level), 1);
        do_release();
        drain("t4_release", 20);
        check_val("t4_level_off", int'(w_level), 0);

        // Reset during ARM_PR with cnt=2.
        button = 1'b0;
        step(5);
        rst_n = 1'b0;
        #0.2;
        led_exp = 0;
        check_val("t5a_level", int'(w_level), 0);
        check_val("t5a_led", int'(w_led), 0);
        step(3);
        check_val("t5a_press_in_rst", int'(w_press), 0);
        rst_n = 1'b1;
        push_ev(K_PRESS, cyc + c_LAT);
        led_exp = 1;
        drain("t5a_press", 20);
        check_val("t5a_led_after", int'(w_led), led_exp);

        // Reset during HELD.
        step(2);
        rst_n = 1'b0;
        #0.2;
        led_exp = 0;
        check_val("t5b_level", int'(w_level), 0);
        check_val("t5b_led", int'(w_led), 0);
        step(2);
        rst_n = 1'b1;
        push_ev(K_PRESS, cyc + c_LAT);
        led_exp = 1;
        drain("t5b_press", 20);
        check_val("t5b_level_after", int'(w_level), 1);
        do_release();
        drain("t5b_release", 20);

        // Two full press/release cycles.
        for (int i = 0; i < 2; i++) begin
            do_press();
            drain("t6_press", 20);
            check_val("t6_led_press", int'(w_led), led_exp);
            do_release();
            drain("t6_release", 20);
            check_val("t6_led_release", int'(w_led), led_exp);
            check_val("t6_level_off", int'(w_level), 0);
        end

        step(5);
        check_val("press_count", n_press_seen, n_press_exp);
        check_val("release_count", n_rel_seen, n_rel_exp);
        check_val("long_count", n_long_seen, n_long_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
